// File: rtl/hall_commutator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hall_commutator_pkg
// Description : Shared constants and helpers for the hall commutator: the
//               clockwise hall order, the clockwise commutation table, the
//               safe (all phases floating) pattern and the FSM state codes.
// Revision    : 1.0  initial release
// ============================================================================
package hall_commutator_pkg;

    // FSM state codes (kept as plain localparams for legacy tools)
    localparam logic [1:0] c_st_init  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_fault = 2'd2;

    // Safe output pattern: nothing driven high, all phases floating
    localparam logic [2:0] c_safe_u = 3'b000;
    localparam logic [2:0] c_safe_z = 3'b111;

    typedef struct packed {
        logic [2:0] u;
        logic [2:0] z;
    } phase_t;

    // 000 and 111 cannot be produced by a healthy sensor set
    function automatic logic hall_valid(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // Successor in the clockwise order 101->100->110->010->011->001->101
    function automatic logic [2:0] hall_next_cw(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            3'b101:  nxt = 3'b100;
            3'b100:  nxt = 3'b110;
            3'b110:  nxt = 3'b010;
            3'b010:  nxt = 3'b011;
            3'b011:  nxt = 3'b001;
            3'b001:  nxt = 3'b101;
            default: nxt = 3'b000;
        endcase
        return nxt;
    endfunction

    // Predecessor in the clockwise order (i.e. the counter-clockwise step)
    function automatic logic [2:0] hall_prev_cw(input logic [2:0] code);
        logic [2:0] prv;
        case (code)
            3'b101:  prv = 3'b001;
            3'b100:  prv = 3'b101;
            3'b110:  prv = 3'b100;
            3'b010:  prv = 3'b110;
            3'b011:  prv = 3'b010;
            3'b001:  prv = 3'b011;
            default: prv = 3'b000;
        endcase
        return prv;
    endfunction

    // Clockwise commutation table; invalid codes map to the safe pattern
    function automatic phase_t cw_table(input logic [2:0] code);
        phase_t p;
        case (code)
            3'b101:  p = '{u: 3'b100, z: 3'b001};
            3'b100:  p = '{u: 3'b100, z: 3'b010};
            3'b110:  p = '{u: 3'b010, z: 3'b100};
            3'b010:  p = '{u: 3'b010, z: 3'b001};
            3'b011:  p = '{u: 3'b001, z: 3'b010};
            3'b001:  p = '{u: 3'b001, z: 3'b100};
            default: p = '{u: c_safe_u, z: c_safe_z};
        endcase
        return p;
    endfunction

endpackage : hall_commutator_pkg
`default_nettype wire

// File: rtl/hall_commutator_if.sv
`default_nettype none
// ============================================================================
// Module      : hall_commutator_if
// Description : Signal bundle between the hall pins / speed loop and the
//               commutator. The master drives hall inputs and control, the
//               slave (the commutator) drives the phase pattern and status.
//   h[2:0]         raw hall inputs {h1,h2,h3}, asynchronous
//   enable         0 forces safe outputs
//   dir            0 clockwise, 1 counter-clockwise
//   fault_clear    single-cycle pulse clearing a latched fault
//   u[2:0], z[2:0] phase driven high / phase floating
//   step, step_dir step pulse and its direction
//   period, period_valid  commutation period measurement
//   fault          sticky fault flag
// Revision    : 1.0  initial release
// ============================================================================
interface hall_commutator_if #(
    parameter int PERIOD_WIDTH = 16
);
    logic [2:0]              h;
    logic                    enable;
    logic                    dir;
    logic                    fault_clear;
    logic [2:0]              u;
    logic [2:0]              z;
    logic                    step;
    logic                    step_dir;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    fault;

    modport master (
        output h, enable, dir, fault_clear,
        input  u, z, step, step_dir, period, period_valid, fault
    );

    modport slave (
        input  h, enable, dir, fault_clear,
        output u, z, step, step_dir, period, period_valid, fault
    );
endinterface : hall_commutator_if
`default_nettype wire

// File: rtl/hall_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : hall_input_filter
// Description : Two-flop synchroniser for the raw hall inputs followed by a
//               debounce: a code is accepted as h_stable only after
//               FILTER_CYCLES consecutive identical synchronised samples.
//   clock, reset   system clock, synchronous active-high reset
//   h_raw[2:0]     asynchronous hall pins
//   h_stable[2:0]  filtered hall code
// Revision    : 1.0  initial release
// ============================================================================
module hall_input_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic [2:0] h_raw,
    output logic      [2:0] h_stable
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_cand;
    logic [2:0]       r_stable;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Number of consecutive samples equal to the sample just taken,
    // saturating at FILTER_CYCLES.
    always_comb begin
        w_count_next = r_count;
        if (r_sync2 != r_cand) begin
            w_count_next = CNT_W'(1);
        end else if (r_count != CNT_W'(FILTER_CYCLES)) begin
            w_count_next = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= 3'b000;
            r_sync2  <= 3'b000;
            r_cand   <= 3'b000;
            r_count  <= '0;
            r_stable <= 3'b000;
        end else begin
            r_sync1 <= h_raw;
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_count <= w_count_next;
            if (w_count_next == CNT_W'(FILTER_CYCLES)) begin
                r_stable <= r_sync2;
            end
        end
    end

    assign h_stable = r_stable;

endmodule : hall_input_filter
`default_nettype wire

// File: rtl/hall_commutator.sv
`default_nettype none
// ============================================================================
// Module      : hall_commutator
// Description : Six-step commutation for one BLDC channel. Filters the hall
//               inputs, drives the per-phase high/float pattern for the
//               selected direction, flags invalid/skipped hall transitions
//               with a sticky fault and measures the commutation period.
//   clock, reset   system clock, synchronous active-high reset
//   bus (slave)    hall inputs, control, phase pattern and status
// Revision    : 1.0  initial release
// ============================================================================
module hall_commutator
    import hall_commutator_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int PERIOD_WIDTH  = 16,
    parameter int FAULT_LIMIT   = 3
) (
    input  wire logic         clock,
    input  wire logic         reset,
    hall_commutator_if.slave  bus
);

    localparam int                      BAD_W        = $clog2(FAULT_LIMIT + 1);
    localparam logic [PERIOD_WIDTH-1:0] c_period_max = '1;

    logic [2:0]              w_h_stable;
    logic [2:0]              r_h_last;
    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [BAD_W-1:0]        r_bad;
    logic [BAD_W-1:0]        w_bad_next;

    logic                    w_changed;
    logic                    w_is_cw;
    logic                    w_is_ccw;
    logic                    w_step_evt;
    logic                    w_bad_evt;
    logic                    w_drive;
    phase_t                  w_phase;
    logic [2:0]              w_u_ccw;

    logic [2:0]              r_u;
    logic [2:0]              r_z;
    logic                    r_step;
    logic                    r_step_dir;
    logic                    r_fault;
    logic [PERIOD_WIDTH-1:0] r_counter;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    r_period_valid;
    logic                    r_seen_step;

    hall_input_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clock    (clock),
        .reset    (reset),
        .h_raw    (bus.h),
        .h_stable (w_h_stable)
    );

    // Transition classification against the previous filtered code. The
    // validity guard on the old code stops an invalid->invalid change from
    // matching the 000 returned by the order helpers.
    assign w_changed  = (w_h_stable != r_h_last);
    assign w_is_cw    = w_changed && hall_valid(r_h_last) && hall_valid(w_h_stable)
                        && (hall_next_cw(r_h_last) == w_h_stable);
    assign w_is_ccw   = w_changed && hall_valid(r_h_last) && hall_valid(w_h_stable)
                        && (hall_prev_cw(r_h_last) == w_h_stable);
    assign w_step_evt = (r_state == c_st_run) && (w_is_cw || w_is_ccw);
    assign w_bad_evt  = (r_state == c_st_run) && w_changed && !(w_is_cw || w_is_ccw);

    always_comb begin
        w_state_next = r_state;
        w_bad_next   = r_bad;
        case (r_state)
            c_st_init: begin
                w_bad_next = '0;
                if (hall_valid(w_h_stable)) begin
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                if (w_step_evt) begin
                    w_bad_next = '0;
                end else if (w_bad_evt) begin
                    w_bad_next = r_bad + BAD_W'(1);
                    if ((int'(r_bad) + 1) >= FAULT_LIMIT) begin
                        w_state_next = c_st_fault;
                    end
                end
            end
            c_st_fault: begin
                // A clear beats any bad event arriving in the same cycle
                if (bus.fault_clear) begin
                    w_state_next = c_st_init;
                    w_bad_next   = '0;
                end
            end
            default: begin
                w_state_next = c_st_init;
                w_bad_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so that the phase pattern
    // and the fault flag change on the same edge as the state itself.
    assign w_phase = cw_table(w_h_stable);
    assign w_u_ccw = ~(w_phase.u | w_phase.z) & 3'b111;
    assign w_drive = bus.enable && (w_state_next == c_st_run) && hall_valid(w_h_stable);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_st_init;
            r_bad          <= '0;
            r_h_last       <= 3'b000;
            r_u            <= c_safe_u;
            r_z            <= c_safe_z;
            r_step         <= 1'b0;
            r_step_dir     <= 1'b0;
            r_fault        <= 1'b0;
            r_counter      <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_seen_step    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bad    <= w_bad_next;
            r_h_last <= w_h_stable;
            r_step   <= w_step_evt;
            r_fault  <= (w_state_next == c_st_fault);

            if (w_drive) begin
                r_u <= bus.dir ? w_u_ccw : w_phase.u;
                r_z <= w_phase.z;
            end else begin
                r_u <= c_safe_u;
                r_z <= c_safe_z;
            end

            if (w_step_evt) begin
                r_step_dir <= w_is_ccw;
            end

            // The first step after entering RUN only closes the interval
            // started at RUN entry, so period_valid waits for the second.
            if (r_state == c_st_run) begin
                if (w_step_evt) begin
                    r_period    <= (r_counter == c_period_max) ? c_period_max
                                                               : r_counter + 1'b1;
                    r_counter   <= '0;
                    r_seen_step <= 1'b1;
                    if (r_seen_step) begin
                        r_period_valid <= 1'b1;
                    end
                end else if (r_counter != c_period_max) begin
                    r_counter <= r_counter + 1'b1;
                end
            end else begin
                r_counter      <= '0;
                r_period_valid <= 1'b0;
                r_seen_step    <= 1'b0;
            end
        end
    end

    assign bus.u            = r_u;
    assign bus.z            = r_z;
    assign bus.step         = r_step;
    assign bus.step_dir     = r_step_dir;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.fault        = r_fault;

endmodule : hall_commutator
`default_nettype wire
